// File: rtl/fetch_stage.sv
// Fetch stage of a 5-stage MIPS pipeline: the PC register plus the IF/ID latch.
// Each edge performs one action, picked in priority order:
//   redirect (pc_src=1)  >  hold (write=0)  >  advance.
// Operand fields rs/rt go back to the hazard unit combinationally.
// Hold protocol: `write` acts as a ready from downstream. When write=1 the
// fetched word is accepted into IF/ID on the edge. When write=0 the PC and
// IF/ID stay exactly as they are. pc_src overrides write, because the
// redirect comes from an older instruction.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write,
  input  logic             pc_src,
  input  logic [31:0]      branch_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      instr_FD,
  output logic [31:0]      pcPlus4_FD,
  output logic             valid_FD,
  output logic [4:0]       rs_FD,
  output logic [4:0]       rt_FD,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'd0,
    ACT_HOLD     = 2'd1,
    ACT_REDIRECT = 2'd2
  } action_t;

  action_t     action;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        cnt_full;

  assign pc_plus4 = pc + 32'd4;  // wraps modulo 2^32
  assign cnt_full = &stall_count;

  // Select this edge's action; redirect outranks hold
  always_comb begin
    action = ACT_ADVANCE;
    if (pc_src)      action = ACT_REDIRECT;
    else if (!write) action = ACT_HOLD;
  end

  // PC register: targets are forced to word alignment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      case (action)
        ACT_REDIRECT: pc <= {branch_target[31:2], 2'b00};
        ACT_ADVANCE:  pc <= pc_plus4;
        default:      pc <= pc;
      endcase
    end
  end

  // IF/ID latch: a redirect flushes it to a bubble, a hold keeps it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_FD   <= 32'd0;
      pcPlus4_FD <= 32'd0;
      valid_FD   <= 1'b0;
    end else begin
      case (action)
        ACT_REDIRECT: begin
          instr_FD   <= 32'd0;
          pcPlus4_FD <= 32'd0;
          valid_FD   <= 1'b0;
        end
        ACT_ADVANCE: begin
          instr_FD   <= imem_data;
          pcPlus4_FD <= pc_plus4;
          valid_FD   <= 1'b1;
        end
        default: begin
          instr_FD   <= instr_FD;
          pcPlus4_FD <= pcPlus4_FD;
          valid_FD   <= valid_FD;
        end
      endcase
    end
  end

  // Count hold cycles and saturate at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (action == ACT_HOLD && !cnt_full) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign imem_addr = pc;
  assign rs_FD     = instr_FD[25:21];
  assign rt_FD     = instr_FD[20:16];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The main instance uses the default
// parameters. A second instance (RESET_PC=FFFF_FFFC, CNT_W=4) covers PC
// wrap-around and counter saturation.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic        pc_src;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr_FD;
  logic [31:0] pcPlus4_FD;
  logic        valid_FD;
  logic [4:0]  rs_FD;
  logic [4:0]  rt_FD;
  logic [15:0] stall_count;

  logic        rst2_n;
  logic        write2;
  logic        pc_src2;
  logic [31:0] branch_target2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_data2;
  logic [31:0] instr2;
  logic [31:0] pcplus4_2;
  logic        valid2;
  logic [4:0]  rs2;
  logic [4:0]  rt2;
  logic [3:0]  stall2;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [31:0] exp_instr;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .write(write), .pc_src(pc_src),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_FD(instr_FD), .pcPlus4_FD(pcPlus4_FD), .valid_FD(valid_FD),
    .rs_FD(rs_FD), .rt_FD(rt_FD), .stall_count(stall_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .write(write2), .pc_src(pc_src2),
    .branch_target(branch_target2), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .instr_FD(instr2), .pcPlus4_FD(pcplus4_2), .valid_FD(valid2),
    .rs_FD(rs2), .rt_FD(rt2), .stall_count(stall2)
  );

  // Instruction memory: two fixed words, and an address-derived pattern elsewhere
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem = 32'h8C22_0004;
      32'h0000_0004: mem = 32'h0041_1820;
      default:       mem = a ^ 32'h1234_5678;
    endcase
  endfunction

  assign imem_data  = mem(imem_addr);
  assign imem_data2 = mem(imem_addr2);

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; write = 1'b1; pc_src = 1'b0; branch_target = 32'd0;
    rst2_n = 1'b0; write2 = 1'b1; pc_src2 = 1'b0; branch_target2 = 32'd0;

    // Reset state
    #1;
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_instr", instr_FD, 32'h0);
    check("rst_pcplus4", pcPlus4_FD, 32'h0);
    check("rst_valid", {31'd0, valid_FD}, 32'd0);
    check("rst_rs", {27'd0, rs_FD}, 32'd0);
    check("rst_rt", {27'd0, rt_FD}, 32'd0);
    check("rst_stall", {16'd0, stall_count}, 32'd0);
    step(); step();
    check("rst_held_addr", imem_addr, 32'h0);
    rst_n = 1'b1;

    // Sequential fetch
    step();
    check("e1_instr", instr_FD, 32'h8C22_0004);
    check("e1_pcplus4", pcPlus4_FD, 32'd4);
    check("e1_rs", {27'd0, rs_FD}, 32'd1);
    check("e1_rt", {27'd0, rt_FD}, 32'd2);
    check("e1_valid", {31'd0, valid_FD}, 32'd1);
    step();
    check("e2_instr", instr_FD, 32'h0041_1820);
    check("e2_addr", imem_addr, 32'd8);

    // Load-use hold of one cycle
    write = 1'b0;
    step();
    check("hold_addr", imem_addr, 32'd8);
    check("hold_instr", instr_FD, 32'h0041_1820);
    check("hold_stall", {16'd0, stall_count}, 32'd1);
    write = 1'b1;
    step();
    check("adv8_instr", instr_FD, 32'h1234_5670);
    check("adv8_pcplus4", pcPlus4_FD, 32'd12);
    check("adv8_stall", {16'd0, stall_count}, 32'd1);

    // Redirect
    pc_src = 1'b1; branch_target = 32'h40;
    step();
    check("redir_addr", imem_addr, 32'h40);
    check("redir_valid", {31'd0, valid_FD}, 32'd0);
    check("redir_instr", instr_FD, 32'h0);
    pc_src = 1'b0;
    step();
    check("tgt_pcplus4", pcPlus4_FD, 32'h44);
    check("tgt_valid", {31'd0, valid_FD}, 32'd1);
    check("tgt_instr", instr_FD, 32'h1234_5638);

    // Redirect during hold: unaligned target is forced to a word boundary
    write = 1'b0; pc_src = 1'b1; branch_target = 32'h103;
    step();
    check("rh_addr", imem_addr, 32'h100);
    check("rh_valid", {31'd0, valid_FD}, 32'd0);
    check("rh_instr", instr_FD, 32'h0);
    check("rh_stall", {16'd0, stall_count}, 32'd1);
    // A hold on a bubble still counts
    pc_src = 1'b0;
    step();
    check("bub_valid", {31'd0, valid_FD}, 32'd0);
    check("bub_stall", {16'd0, stall_count}, 32'd2);
    check("bub_addr", imem_addr, 32'h100);

    // Operands stay stable across a two-cycle hold
    write = 1'b1;
    step();
    exp_instr = 32'h0000_0100 ^ 32'h1234_5678;
    check("adv100_instr", instr_FD, exp_instr);
    write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("h2_instr", instr_FD, exp_instr);
      check("h2_rs", {27'd0, rs_FD}, {27'd0, exp_instr[25:21]});
      check("h2_rt", {27'd0, rt_FD}, {27'd0, exp_instr[20:16]});
      check("h2_stall", {16'd0, stall_count}, 32'd3 + 32'(i));
    end

    // Async reset between edges, with a redirect pending
    pc_src = 1'b1; branch_target = 32'h200;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_addr", imem_addr, 32'h0);
    check("ar_instr", instr_FD, 32'h0);
    check("ar_pcplus4", pcPlus4_FD, 32'h0);
    check("ar_valid", {31'd0, valid_FD}, 32'd0);
    check("ar_stall", {16'd0, stall_count}, 32'd0);
    pc_src = 1'b0; write = 1'b1;
    #1;
    rst_n = 1'b1;
    step();
    check("ar_refetch", instr_FD, 32'h8C22_0004);
    check("ar_refetch_addr", imem_addr, 32'd4);

    // PC wrap-around and saturating 4-bit counter
    rst2_n = 1'b1;
    step();
    check("wrap_addr", imem_addr2, 32'h0);
    check("wrap_pcplus4", pcplus4_2, 32'h0);
    check("wrap_instr", instr2, 32'hFFFF_FFFC ^ 32'h1234_5678);
    write2 = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check("sat_14", {28'd0, stall2}, 32'd14);
    for (int i = 0; i < 6; i++) step();
    check("sat_20", {28'd0, stall2}, 32'd15);
    check("sat_addr", imem_addr2, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
